// File: rtl/trigger_frame_builder.sv
// Self-triggering ADC front end: baseline subtract, threshold trigger,
// and framed AXI-Stream output with pre/post acquisition and length cap.
module trigger_frame_builder #(
   parameter int SAMPLE_NUM_PER_CLK = 8,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int TIMESTAMP_WIDTH    = 48,
   parameter int MAX_PRE_LENGTH     = 4,
   parameter int MAX_POST_LENGTH    = 4,
   parameter int MAX_FRAME_LENGTH   = 64
) (
   input  logic                                         ACLK,
   input  logic                                         ARESET,
   input  logic                                         SET_CONFIG,
   input  logic                                         STOP,
   input  logic [SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic                                         S_AXIS_TVALID,
   input  logic [TIMESTAMP_WIDTH-1:0]                   TIMESTAMP,
   input  logic [SAMPLE_WIDTH-1:0]                      BASELINE,
   input  logic [SAMPLE_WIDTH-1:0]                      RISING_THRESHOLD,
   input  logic [SAMPLE_WIDTH-1:0]                      FALLING_THRESHOLD,
   input  logic [$clog2(MAX_PRE_LENGTH):0]              PRE_LENGTH,
   input  logic [$clog2(MAX_POST_LENGTH):0]             POST_LENGTH,
   input  logic [$clog2(MAX_FRAME_LENGTH):0]            MAX_LENGTH,
   output logic [SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [TIMESTAMP_WIDTH+7:0]                   M_AXIS_TUSER,
   output logic                                         M_AXIS_TVALID,
   output logic                                         M_AXIS_TLAST,
   output logic [31:0]                                  FRAME_COUNT
);
   localparam int N   = SAMPLE_NUM_PER_CLK;
   localparam int W   = SAMPLE_WIDTH;
   localparam int TW  = TIMESTAMP_WIDTH;
   localparam int PW  = $clog2(MAX_PRE_LENGTH) + 1;
   localparam int QW  = $clog2(MAX_POST_LENGTH) + 1;
   localparam int MW  = $clog2(MAX_FRAME_LENGTH) + 1;
   localparam int PHW = (PW > QW) ? PW : QW;
   localparam int WW  = $clog2(MAX_PRE_LENGTH + 2);

   typedef enum logic [2:0] {IDLE, ACTIVE, POST, FLUSH, HOLDOFF} state_t;

   function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      r = {a[W-1], a} - {b[W-1], b};
      if (r[W] != r[W-1]) return {r[W], {(W-1){~r[W]}}};
      return r[W-1:0];
   endfunction

   logic signed [W-1:0] cfg_base, cfg_rise, cfg_fall;
   logic [PW-1:0]       cfg_pre, pre_in;
   logic [QW-1:0]       cfg_post, post_in;
   logic [MW-1:0]       cfg_max, max_in;

   logic [N*W-1:0]      d_vec;
   logic                any_hit, all_below;

   logic [N*W-1:0]      s0_data;
   logic [TW-1:0]       s0_ts;
   logic                s0_hit, s0_below;
   logic [N*W-1:0]      dl_data [MAX_PRE_LENGTH];
   logic [TW-1:0]       dl_ts   [MAX_PRE_LENGTH];
   logic                dl_hit  [MAX_PRE_LENGTH];
   logic [N*W-1:0]      tap_data;
   logic [TW-1:0]       tap_ts;
   logic                tap_hit;

   state_t              state, state_nxt;
   logic [MW-1:0]       beat_cnt, beat_nxt;
   logic [PHW-1:0]      ph_cnt, ph_nxt;
   logic [WW-1:0]       warm;
   logic                hit_e, emit, last, trunc, post_end;

   // Clamp incoming configuration before it is latched
   always_comb begin
      pre_in  = (PRE_LENGTH > PW'(MAX_PRE_LENGTH)) ? PW'(MAX_PRE_LENGTH) : PRE_LENGTH;
      post_in = (POST_LENGTH > QW'(MAX_POST_LENGTH)) ? QW'(MAX_POST_LENGTH) : POST_LENGTH;
      max_in  = (MAX_LENGTH == '0 || MAX_LENGTH > MW'(MAX_FRAME_LENGTH)) ?
                MW'(MAX_FRAME_LENGTH) : MAX_LENGTH;
   end

   // Configuration registers, loaded only on SET_CONFIG
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cfg_base <= '0;
         cfg_rise <= W'(1024);
         cfg_fall <= W'(512);
         cfg_pre  <= PW'(1);
         cfg_post <= QW'(1);
         cfg_max  <= MW'(MAX_FRAME_LENGTH);
      end else if (SET_CONFIG) begin
         cfg_base <= BASELINE;
         cfg_rise <= RISING_THRESHOLD;
         cfg_fall <= FALLING_THRESHOLD;
         cfg_pre  <= pre_in;
         cfg_post <= post_in;
         cfg_max  <= max_in;
      end
   end

   // Saturating baseline subtraction and per-beat threshold flags
   always_comb begin
      d_vec     = '0;
      any_hit   = 1'b0;
      all_below = 1'b1;
      for (int i = 0; i < N; i++) begin
         d_vec[i*W +: W] = sat_sub(S_AXIS_TDATA[i*W +: W], cfg_base);
         if ($signed(d_vec[i*W +: W]) > cfg_rise) any_hit = 1'b1;
         if (!($signed(d_vec[i*W +: W]) < cfg_fall)) all_below = 1'b0;
      end
   end

   // Stage0 register and pre-acquisition delay line
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         s0_data  <= '0;
         s0_ts    <= '0;
         s0_hit   <= 1'b0;
         s0_below <= 1'b1;
         for (int i = 0; i < MAX_PRE_LENGTH; i++) begin
            dl_data[i] <= '0;
            dl_ts[i]   <= '0;
            dl_hit[i]  <= 1'b0;
         end
      end else begin
         s0_data    <= d_vec;
         s0_ts      <= TIMESTAMP;
         s0_hit     <= S_AXIS_TVALID & any_hit;
         s0_below   <= ~S_AXIS_TVALID | all_below;
         dl_data[0] <= s0_data;
         dl_ts[0]   <= s0_ts;
         dl_hit[0]  <= s0_hit;
         for (int i = 1; i < MAX_PRE_LENGTH; i++) begin
            dl_data[i] <= dl_data[i-1];
            dl_ts[i]   <= dl_ts[i-1];
            dl_hit[i]  <= dl_hit[i-1];
         end
      end
   end

   // Select the delay-line tap matching the configured pre length
   always_comb begin
      tap_data = s0_data;
      tap_ts   = s0_ts;
      tap_hit  = s0_hit;
      for (int i = 0; i < MAX_PRE_LENGTH; i++) begin
         if (cfg_pre == PW'(i + 1)) begin
            tap_data = dl_data[i];
            tap_ts   = dl_ts[i];
            tap_hit  = dl_hit[i];
         end
      end
   end

   assign hit_e = s0_hit && (warm == '0);

   // Frame FSM next state, emit and last-beat decisions
   always_comb begin
      state_nxt = state;
      ph_nxt    = ph_cnt;
      emit      = 1'b0;
      last      = 1'b0;
      trunc     = 1'b0;
      post_end  = 1'b0;
      unique case (state)
         IDLE: begin
            if (hit_e && !STOP && !M_AXIS_TLAST) begin
               emit      = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            emit = 1'b1;
            if (!hit_e && s0_below) begin
               if (cfg_post == '0) post_end = 1'b1;
               else begin
                  state_nxt = POST;
                  ph_nxt    = '0;
               end
            end
         end
         POST: begin
            emit = 1'b1;
            if (hit_e) state_nxt = ACTIVE;
            else if (ph_cnt == PHW'(cfg_post) - PHW'(1)) post_end = 1'b1;
            else ph_nxt = ph_cnt + PHW'(1);
         end
         FLUSH: begin
            emit = 1'b1;
            if (hit_e) state_nxt = ACTIVE;
            else if (ph_cnt == PHW'(cfg_pre) - PHW'(1)) begin
               state_nxt = IDLE;
               last      = 1'b1;
            end else ph_nxt = ph_cnt + PHW'(1);
         end
         HOLDOFF: begin
            if (s0_below) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (post_end) begin
         if (cfg_pre == '0) begin
            state_nxt = IDLE;
            last      = 1'b1;
         end else begin
            state_nxt = FLUSH;
            ph_nxt    = '0;
         end
      end
      if (emit && beat_cnt == cfg_max - MW'(1)) begin
         last      = 1'b1;
         trunc     = 1'b1;
         state_nxt = HOLDOFF;
      end
      beat_nxt = (emit && !last) ? beat_cnt + MW'(1) : '0;
   end

   // State register, frame counters and trigger warm-up
   always_ff @(posedge ACLK) begin
      if (ARESET || SET_CONFIG) begin
         state    <= IDLE;
         beat_cnt <= '0;
         ph_cnt   <= '0;
         warm     <= WW'(MAX_PRE_LENGTH + 1);
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
         ph_cnt   <= ph_nxt;
         if (warm != '0) warm <= warm - WW'(1);
      end
   end

   // Output beat register and completed-frame counter
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         M_AXIS_TDATA  <= '0;
         M_AXIS_TUSER  <= '0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST  <= 1'b0;
         FRAME_COUNT   <= '0;
      end else if (SET_CONFIG) begin
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST  <= 1'b0;
      end else begin
         M_AXIS_TVALID <= emit;
         M_AXIS_TLAST  <= last;
         if (emit) begin
            M_AXIS_TDATA <= tap_data;
            M_AXIS_TUSER <= {tap_ts, 5'b0, tap_hit, trunc, beat_cnt == '0};
         end
         if (last) FRAME_COUNT <= FRAME_COUNT + 32'd1;
      end
   end
endmodule

// File: tb/tb_trigger_frame_builder.sv
// Directed bench for trigger_frame_builder: expected beats are queued by
// the stimulus and matched by an independent output monitor.
module tb_trigger_frame_builder;
   localparam int N  = 8;
   localparam int W  = 16;
   localparam int TW = 48;

   logic              ACLK = 1'b0;
   logic              ARESET = 1'b1;
   logic              SET_CONFIG = 1'b0;
   logic              STOP = 1'b0;
   logic [N*W-1:0]    S_AXIS_TDATA = '0;
   logic              S_AXIS_TVALID = 1'b0;
   logic [TW-1:0]     TIMESTAMP = '0;
   logic [W-1:0]      BASELINE = '0;
   logic [W-1:0]      RISING_THRESHOLD = '0;
   logic [W-1:0]      FALLING_THRESHOLD = '0;
   logic [2:0]        PRE_LENGTH = '0;
   logic [2:0]        POST_LENGTH = '0;
   logic [6:0]        MAX_LENGTH = '0;
   logic [N*W-1:0]    M_AXIS_TDATA;
   logic [TW+7:0]     M_AXIS_TUSER;
   logic              M_AXIS_TVALID;
   logic              M_AXIS_TLAST;
   logic [31:0]       FRAME_COUNT;

   trigger_frame_builder dut (
      .ACLK(ACLK), .ARESET(ARESET), .SET_CONFIG(SET_CONFIG), .STOP(STOP),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
      .TIMESTAMP(TIMESTAMP), .BASELINE(BASELINE),
      .RISING_THRESHOLD(RISING_THRESHOLD), .FALLING_THRESHOLD(FALLING_THRESHOLD),
      .PRE_LENGTH(PRE_LENGTH), .POST_LENGTH(POST_LENGTH), .MAX_LENGTH(MAX_LENGTH),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
      .FRAME_COUNT(FRAME_COUNT)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [N*W-1:0] data;
      logic [TW+7:0]  user;
      logic           last;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   l0[64];
   int   l1[64];
   bit   stp[64];
   int   fill = 0;

   always @(posedge ACLK) cyc <= cyc + 1;

   // Monitor: every presented beat must match the head of the queue
   always @(negedge ACLK) begin
      if (!ARESET && M_AXIS_TVALID) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_beat: got data %h user %h last %b at cycle %0d, required no beat",
                     M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (M_AXIS_TDATA === e.data && M_AXIS_TUSER === e.user &&
                M_AXIS_TLAST === e.last && cyc == e.cyc)
               passes++;
            else
               $display("FAIL beat: got data %h user %h last %b cyc %0d, required data %h user %h last %b cyc %0d",
                        M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, cyc,
                        e.data, e.user, e.last, e.cyc);
         end
      end
   end

   function automatic logic [N*W-1:0] mk(input int f, input int a, input int b);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = W'(f);
      v[0 +: W] = W'(a);
      v[W +: W] = W'(b);
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic drive(input logic [N*W-1:0] d, input logic v,
                        input logic [TW-1:0] ts, input logic cfg, input logic s);
      @(posedge ACLK);
      #1;
      S_AXIS_TDATA  = d;
      S_AXIS_TVALID = v;
      TIMESTAMP     = ts;
      SET_CONFIG    = cfg;
      STOP          = s;
   endtask

   task automatic set_ports(input int b, input int r, input int f,
                            input int pre, input int post, input int mx);
      BASELINE          = W'(b);
      RISING_THRESHOLD  = W'(r);
      FALLING_THRESHOLD = W'(f);
      PRE_LENGTH        = 3'(pre);
      POST_LENGTH       = 3'(post);
      MAX_LENGTH        = 7'(mx);
   endtask

   task automatic configure(input int b, input int r, input int f,
                            input int pre, input int post, input int mx);
      set_ports(b, r, f, pre, post, mx);
      drive('0, 1'b0, '0, 1'b1, 1'b0);
      t0 = cyc + 1;
      fill = 0;
      for (int k = 0; k < 64; k++) begin
         l0[k]  = 0;
         l1[k]  = 0;
         stp[k] = 1'b0;
      end
   endtask

   task automatic expect_beat(input int k, input int pre, input logic [N*W-1:0] d,
                              input longint tsb, input bit hit, input bit tr,
                              input bit first, input bit last);
      exp_t e;
      e.data = d;
      e.user = {TW'(tsb + k), 5'b0, hit, tr, first};
      e.last = last;
      e.cyc  = t0 + k + 2 + pre;
      sb.push_back(e);
   endtask

   task automatic stream(input int len, input longint tsb, input int cfgat);
      for (int k = 0; k < len; k++)
         drive(mk(fill, l0[k], l1[k]), 1'b1, TW'(tsb + k), 1'b0, stp[k]);
      for (int k = 0; k < len; k++) ;
      for (int k = 0; k < 12; k++) drive('0, 1'b0, '0, 1'b0, 1'b0);
      if (cfgat >= 0) ;
   endtask

   task automatic stream_cfg(input int len, input longint tsb, input int cfgat);
      for (int k = 0; k < len; k++)
         drive(mk(fill, l0[k], l1[k]), 1'b1, TW'(tsb + k), k == cfgat, stp[k]);
      for (int k = 0; k < 12; k++) drive('0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_tvalid", M_AXIS_TVALID, 0);
      chk("rst_tlast", M_AXIS_TLAST, 0);
      chk("rst_tdata_nonzero", M_AXIS_TDATA != '0, 0);
      chk("rst_tuser_nonzero", M_AXIS_TUSER != '0, 0);
      chk("rst_frame_count", FRAME_COUNT, 0);

      // Basic frame: pre 2, post 3, single hit at beat 10
      configure(0, 1024, 512, 2, 3, 0);
      l0[10] = 2000;
      for (int k = 8; k <= 14; k++)
         expect_beat(k, 2, mk(0, l0[k], 0), 1000, k == 10, 0, k == 8, k == 14);
      stream(25, 1000, -1);
      chk("fc_basic", FRAME_COUNT, 1);

      // Retrigger during post extends one frame
      configure(0, 1024, 512, 2, 3, 0);
      l0[10] = 2000;
      l0[12] = 2000;
      for (int k = 8; k <= 16; k++)
         expect_beat(k, 2, mk(0, l0[k], 0), 2000, k == 10 || k == 12, 0, k == 8, k == 16);
      stream(30, 2000, -1);
      chk("fc_retrigger", FRAME_COUNT, 2);

      // Truncation at 5 beats, holdoff, then a fresh frame
      configure(0, 1024, 512, 1, 1, 5);
      for (int k = 10; k < 30; k++) l0[k] = 2000;
      l0[40] = 2000;
      for (int k = 9; k <= 13; k++)
         expect_beat(k, 1, mk(0, l0[k], 0), 3000, k >= 10, k == 13, k == 9, k == 13);
      for (int k = 39; k <= 42; k++)
         expect_beat(k, 1, mk(0, l0[k], 0), 3000, k == 40, 0, k == 39, k == 42);
      stream(50, 3000, -1);
      chk("fc_truncate", FRAME_COUNT, 4);

      // Negative saturation, pre 0 post 0
      configure(100, 1024, 512, 0, 0, 0);
      l0[10] = -32768;
      l1[10] = 2000;
      expect_beat(10, 0, mk(-100, -32768, 1900), 4000, 1, 0, 1, 0);
      expect_beat(11, 0, mk(-100, -100, -100), 4000, 0, 0, 0, 1);
      stream(20, 4000, -1);
      chk("fc_sat_neg", FRAME_COUNT, 5);

      // Positive saturation
      configure(-1, 1024, 512, 0, 0, 0);
      l0[10] = 32767;
      expect_beat(10, 0, mk(1, 32767, 1), 5000, 1, 0, 1, 0);
      expect_beat(11, 0, mk(1, 1, 1), 5000, 0, 0, 0, 1);
      stream(20, 5000, -1);
      chk("fc_sat_pos", FRAME_COUNT, 6);

      // STOP blocks a new frame but not one in progress
      configure(0, 1024, 512, 2, 3, 0);
      l0[10] = 2000;
      for (int k = 0; k <= 12; k++) stp[k] = 1'b1;
      l0[20] = 2000;
      for (int k = 22; k < 40; k++) stp[k] = 1'b1;
      for (int k = 18; k <= 24; k++)
         expect_beat(k, 2, mk(0, l0[k], 0), 6000, k == 20, 0, k == 18, k == 24);
      stream(40, 6000, -1);
      chk("fc_stop", FRAME_COUNT, 7);

      // SET_CONFIG aborts a frame; warm-up and new thresholds follow
      configure(0, 1024, 512, 1, 3, 0);
      for (int k = 10; k <= 18; k++) l0[k] = 4000;
      l0[30] = 2000;
      l0[40] = 3500;
      for (int k = 9; k <= 11; k++)
         expect_beat(k, 1, mk(0, l0[k], 0), 7000, k >= 10, 0, k == 9, 0);
      for (int k = 39; k <= 42; k++)
         expect_beat(k, 1, mk(0, l0[k], 0), 7000, k == 40, 0, k == 39, k == 42);
      set_ports(0, 3000, 512, 1, 1, 0);
      stream_cfg(50, 7000, 14);
      chk("fc_abort", FRAME_COUNT, 8);

      chk("missing_beats", sb.size(), 0);

      @(posedge ACLK);
      #1 ARESET = 1'b1;
      @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("fc_after_reset", FRAME_COUNT, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
